// File: rtl/rf_write_queue.sv
// Register-file write-back queue: two request ports feed a DEPTH-entry FIFO that drains
// one write per cycle into the 3R1W register RAM. Optional read bypass via `RF_WQ_FWD_EN.
module rf_write_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_valid,
    output logic                       wr0_ready,
    input  logic [4:0]                 wr0_addr,
    input  logic [WIDTH-1:0]           wr0_data,
    input  logic                       wr1_valid,
    output logic                       wr1_ready,
    input  logic [4:0]                 wr1_addr,
    input  logic [WIDTH-1:0]           wr1_data,
    output logic                       ram_we,
    output logic [4:0]                 ram_addrw,
    output logic [WIDTH-1:0]           ram_din,
    input  logic [4:0]                 fwd_addr0,
    input  logic [4:0]                 fwd_addr1,
    input  logic [4:0]                 fwd_addr2,
    output logic                       fwd_hit0,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [WIDTH-1:0]           fwd_data0,
    output logic [WIDTH-1:0]           fwd_data1,
    output logic [WIDTH-1:0]           fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    tail_plus;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic push0, push1, pop;

    // Readiness looks only at registered occupancy so it never chains through valid or pop.
    assign wr0_ready = (count_q <= CW'(DEPTH - 1));
    assign wr1_ready = (count_q <= CW'(DEPTH - 2));

    // r0 is hardwired, so accepted writes to it complete without taking a slot.
    assign push0 = wr0_valid && wr0_ready && (wr0_addr != 5'd0);
    assign push1 = wr1_valid && wr1_ready && (wr1_addr != 5'd0);
    assign pop   = (count_q != '0);

    assign tail_plus = tail_q + PW'(push0);

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_plus + PW'(push1);
        count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
        valid_d = valid_q;
        if (pop)   valid_d[head_q]    = 1'b0;
        if (push0) valid_d[tail_q]    = 1'b1;
        if (push1) valid_d[tail_plus] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage carries no reset; entry validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push0) begin
            addr_mem[tail_q] <= wr0_addr;
            data_mem[tail_q] <= wr0_data;
        end
        if (push1) begin
            addr_mem[tail_plus] <= wr1_addr;
            data_mem[tail_plus] <= wr1_data;
        end
    end

    // Suppressing the write during reset keeps a flushed head from reaching the RAM.
    assign ram_we    = pop && !rst;
    assign ram_addrw = ram_we ? addr_mem[head_q] : 5'd0;
    assign ram_din   = ram_we ? data_mem[head_q] : '0;
    assign count     = count_q;

`ifdef RF_WQ_FWD_EN
    logic [4:0] fwd_addr_a [3];
    assign fwd_addr_a[0] = fwd_addr0;
    assign fwd_addr_a[1] = fwd_addr1;
    assign fwd_addr_a[2] = fwd_addr2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fwd
            logic             hit;
            logic [WIDTH-1:0] data;
            logic [PW-1:0]    idx;
            // Scan oldest to youngest so the last match is the youngest pending write.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                idx  = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    idx = head_q + PW'(i);
                    if (valid_q[idx] && (fwd_addr_a[gi] != 5'd0) &&
                        (addr_mem[idx] == fwd_addr_a[gi])) begin
                        hit  = 1'b1;
                        data = data_mem[idx];
                    end
                end
            end
        end
    endgenerate

    assign fwd_hit0  = g_fwd[0].hit;
    assign fwd_hit1  = g_fwd[1].hit;
    assign fwd_hit2  = g_fwd[2].hit;
    assign fwd_data0 = g_fwd[0].data;
    assign fwd_data1 = g_fwd[1].data;
    assign fwd_data2 = g_fwd[2].data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr0, fwd_addr1, fwd_addr2};
    assign fwd_hit0   = 1'b0;
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data0  = '0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// Bench for rf_write_queue: directed scenarios plus randomized traffic against a queue model.
module tb_rf_write_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr0_valid, wr1_valid;
    logic             wr0_ready, wr1_ready;
    logic [4:0]       wr0_addr, wr1_addr;
    logic [WIDTH-1:0] wr0_data, wr1_data;
    logic             ram_we;
    logic [4:0]       ram_addrw;
    logic [WIDTH-1:0] ram_din;
    logic [4:0]       fwd_addr0, fwd_addr1, fwd_addr2;
    logic             fwd_hit0, fwd_hit1, fwd_hit2;
    logic [WIDTH-1:0] fwd_data0, fwd_data1, fwd_data2;
    logic [2:0]       count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]       a;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t q[$];     // pending writes, oldest first
    ent_t wlog[$];  // RAM writes issued, in order

    always #5 clk = ~clk;

    rf_write_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .ram_we(ram_we), .ram_addrw(ram_addrw), .ram_din(ram_din),
        .fwd_addr0(fwd_addr0), .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data0(fwd_data0), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    task automatic set_idle();
        wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        fwd_addr0 = '0; fwd_addr1 = '0; fwd_addr2 = '0;
    endtask

    // Advance one clock edge and apply the acceptance rules to the model.
    task automatic tick();
        int  n;
        bit  a0, a1;
        @(posedge clk);
        n = q.size();
        if (rst) begin
            q.delete();
        end else begin
            a0 = wr0_valid && (n < DEPTH);
            a1 = wr1_valid && (n <= DEPTH - 2);
            if (n > 0) begin
                $display("ram write addr=%0d data=%h", q[0].a, q[0].d);
                wlog.push_back(q[0]);
                void'(q.pop_front());
            end
            if (a0 && wr0_addr != 5'd0) q.push_back('{wr0_addr, wr0_data});
            if (a1 && wr1_addr != 5'd0) q.push_back('{wr1_addr, wr1_data});
        end
        #1;
    endtask

    function automatic void fwd_model(input logic [4:0] a, output logic h, output logic [WIDTH-1:0] d);
        h = 1'b0;
        d = '0;
`ifdef RF_WQ_FWD_EN
        if (a != 5'd0)
            foreach (q[i])
                if (q[i].a == a) begin
                    h = 1'b1;
                    d = q[i].d;
                end
`endif
    endfunction

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        wr0_valid = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h44;
        wr1_valid = 1'b1; wr1_addr = 5'd6; wr1_data = 32'h66;
        tick();
        tick();
        rst = 1'b0;
        set_idle();
        fwd_addr0 = 5'd4; fwd_addr1 = 5'd6; fwd_addr2 = 5'd4;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (wr0_ready !== 1'b1 || wr1_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b%b exp=11", wr0_ready, wr1_ready);
        end
        checks++; if ({fwd_hit0, fwd_hit1, fwd_hit2} !== 3'b000) begin
            errors++; $display("FAIL reset_fwd_hit got=%b%b%b exp=000", fwd_hit0, fwd_hit1, fwd_hit2);
        end
        tick();
        checks++; if (ram_we !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL reset_drop got we=%b count=%0d exp we=0 count=0", ram_we, count);
        end
    endtask

    task automatic test_pair();
        logic [4:0]       ea [3] = '{5'd5, 5'd7, 5'd0};
        logic [WIDTH-1:0] ed [3] = '{32'h11, 32'h22, 32'h0};
        logic [2:0]       ec [3] = '{3'd2, 3'd1, 3'd0};
        set_idle();
        wr0_valid = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h11;
        wr1_valid = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL pair_no_passthru got=%b exp=0", ram_we); end
        tick();
        set_idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ram_we !== (c < 2) || ram_addrw !== ea[c] || ram_din !== ed[c] || count !== ec[c]) begin
                errors++;
                $display("FAIL pair_cycle%0d got we=%b addr=%0d din=%h count=%0d exp we=%b addr=%0d din=%h count=%0d",
                         c, ram_we, ram_addrw, ram_din, count, (c < 2), ea[c], ed[c], ec[c]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int exp_cnt;
        set_idle();
        for (int c = 0; c < 10; c++) begin
            wr0_valid = 1'b1; wr0_addr = 5'(1 + (2 * c) % 30); wr0_data = 32'h1000 + c;
            wr1_valid = 1'b1; wr1_addr = 5'(2 + (2 * c) % 30); wr1_data = 32'h2000 + c;
            #1;
            exp_cnt = (c == 0) ? 0 : ((c == 1) ? 2 : 3);
            checks++;
            if (count !== 3'(exp_cnt) || wr1_ready !== (exp_cnt <= 2) || wr0_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_cycle%0d got count=%0d r0=%b r1=%b exp count=%0d r0=1 r1=%b",
                         c, count, wr0_ready, wr1_ready, exp_cnt, (exp_cnt <= 2));
            end
            if (q.size() > 0) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addrw !== q[0].a || ram_din !== q[0].d) begin
                    errors++;
                    $display("FAIL bp_order%0d got we=%b addr=%0d din=%h exp we=1 addr=%0d din=%h",
                             c, ram_we, ram_addrw, ram_din, q[0].a, q[0].d);
                end
            end
            tick();
        end
        set_idle();
        for (int c = 0; c < 4; c++) tick();
        #1;
        checks++; if (count !== 3'd0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL bp_drain got count=%0d we=%b exp count=0 we=0", count, ram_we);
        end
    endtask

    task automatic test_addr_zero();
        set_idle();
        wr0_valid = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFF;
        wr1_valid = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h33;
        tick();
        set_idle();
        #1;
        checks++;
        if (count !== 3'd1 || ram_we !== 1'b1 || ram_addrw !== 5'd3 || ram_din !== 32'h33) begin
            errors++;
            $display("FAIL addr_zero got count=%0d we=%b addr=%0d din=%h exp count=1 we=1 addr=3 din=33",
                     count, ram_we, ram_addrw, ram_din);
        end
        tick();
        #1;
        checks++; if (count !== 3'd0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL addr_zero_drain got count=%0d we=%b exp 0/0", count, ram_we);
        end
    endtask

    task automatic test_forward();
        logic             eh [4];
        logic [WIDTH-1:0] ed [4];
`ifdef RF_WQ_FWD_EN
        eh = '{1'b0, 1'b1, 1'b1, 1'b0};
        ed = '{32'h0, 32'hB, 32'hB, 32'h0};
`else
        eh = '{1'b0, 1'b0, 1'b0, 1'b0};
        ed = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
        wlog.delete();
        set_idle();
        wr0_valid = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hA;
        wr1_valid = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hB;
        fwd_addr0 = 5'd0; fwd_addr1 = 5'd9; fwd_addr2 = 5'd9;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (fwd_hit1 !== eh[c] || fwd_data1 !== ed[c] || fwd_hit0 !== 1'b0 || fwd_data0 !== '0) begin
                errors++;
                $display("FAIL fwd_cycle%0d got hit1=%b data1=%h hit0=%b data0=%h exp hit1=%b data1=%h hit0=0 data0=0",
                         c, fwd_hit1, fwd_data1, fwd_hit0, fwd_data0, eh[c], ed[c]);
            end
            tick();
            wr0_valid = 1'b0; wr1_valid = 1'b0;
        end
        checks++;
        if (wlog.size() != 2 || wlog[0].d !== 32'hA || wlog[1].d !== 32'hB ||
            wlog[0].a !== 5'd9 || wlog[1].a !== 5'd9) begin
            errors++;
            $display("FAIL fwd_write_seq got n=%0d exp n=2 (9:A then 9:B)", wlog.size());
        end
        set_idle();
    endtask

    task automatic test_mid_reset();
        wlog.delete();
        set_idle();
        wr0_valid = 1'b1; wr0_addr = 5'd1; wr0_data = 32'hC1;
        wr1_valid = 1'b1; wr1_addr = 5'd2; wr1_data = 32'hC2;
        tick();
        wr0_addr = 5'd3; wr0_data = 32'hC3;
        wr1_addr = 5'd4; wr1_data = 32'hC4;
        tick();
        set_idle();
        #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL midrst_fill got=%0d exp=3", count); end
        rst = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL midrst_we_in_rst got=%b exp=0", ram_we); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ram_we !== 1'b0 || count !== 3'd0) begin
                errors++; $display("FAIL midrst_after%0d got we=%b count=%0d exp 0/0", c, ram_we, count);
            end
            tick();
        end
        checks++; if (wlog.size() != 1) begin
            errors++; $display("FAIL midrst_writes got=%0d exp=1", wlog.size());
        end
    endtask

    task automatic test_random();
        logic             eh;
        logic [WIDTH-1:0] ed;
        logic             ewe;
        logic [4:0]       ea;
        logic [WIDTH-1:0] edin;
        logic [4:0]       fa [3];
        logic             fh [3];
        logic [WIDTH-1:0] fd [3];
        for (int c = 0; c < 300; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            wr0_valid = $urandom_range(0, 1);
            wr0_addr  = 5'($urandom_range(0, 7));
            wr0_data  = $urandom;
            wr1_valid = $urandom_range(0, 1);
            wr1_addr  = 5'($urandom_range(0, 7));
            wr1_data  = $urandom;
            fwd_addr0 = 5'($urandom_range(0, 7));
            fwd_addr1 = 5'($urandom_range(0, 7));
            fwd_addr2 = 5'($urandom_range(0, 7));
            #1;
            ewe  = (q.size() > 0) && !rst;
            ea   = ewe ? q[0].a : 5'd0;
            edin = ewe ? q[0].d : '0;
            checks++;
            if (ram_we !== ewe || ram_addrw !== ea || ram_din !== edin) begin
                errors++;
                $display("FAIL rand_ram%0d got we=%b addr=%0d din=%h exp we=%b addr=%0d din=%h",
                         c, ram_we, ram_addrw, ram_din, ewe, ea, edin);
            end
            checks++;
            if (count !== 3'(q.size()) || wr0_ready !== (q.size() < DEPTH) ||
                wr1_ready !== (q.size() <= DEPTH - 2)) begin
                errors++;
                $display("FAIL rand_occ%0d got count=%0d r0=%b r1=%b exp count=%0d",
                         c, count, wr0_ready, wr1_ready, q.size());
            end
            fa = '{fwd_addr0, fwd_addr1, fwd_addr2};
            fh = '{fwd_hit0, fwd_hit1, fwd_hit2};
            fd = '{fwd_data0, fwd_data1, fwd_data2};
            for (int k = 0; k < 3; k++) begin
                fwd_model(fa[k], eh, ed);
                checks++;
                if (fh[k] !== eh || fd[k] !== ed) begin
                    errors++;
                    $display("FAIL rand_fwd%0d_port%0d got hit=%b data=%h exp hit=%b data=%h",
                             c, k, fh[k], fd[k], eh, ed);
                end
            end
            tick();
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_pair();
        test_backpressure();
        test_addr_zero();
        test_forward();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_queue.md
RF_WRITE_QUEUE -- requirements
Module: rf_write_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of one register entry.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; a power of two, at least 2.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports are listed below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr0_valid / wr0_ready  input / output  1 / 1  write-back request 0 handshake; older of the two ports.
REQ-007 wr0_addr / wr0_data  input / input  5 / WIDTH  request 0 register index and value.
REQ-008 wr1_valid / wr1_ready / wr1_addr / wr1_data  in / out / in / in  1 / 1 / 5 / WIDTH  request 1; younger than request 0.
REQ-009 ram_we / ram_addrw / ram_din  output / output / output  1 / 5 / WIDTH  single write port into the 32-entry 3R1W register RAM.
REQ-010 fwd_addrK, K=0..2  input  5  read-port addresses presented to the RAM this cycle.
REQ-011 fwd_hitK / fwd_dataK  output / output  1 / WIDTH  pending-write bypass result for read port K.
REQ-012 count  output  $clog2(DEPTH+1)  number of valid queue entries.

Function
REQ-013 The block SHALL buffer write-backs in a circular FIFO of DEPTH entries, with head and tail pointers wrapping modulo DEPTH.
REQ-014 wr0_ready SHALL be (count >= 1 free slot); wr1_ready SHALL be (count <= DEPTH-2). Both depend only on registered count, never on valid inputs or on a same-cycle pop.
REQ-015 A port transfers on valid && ready at a clock edge.
REQ-016 When both ports transfer in the same cycle, entry 0 is enqueued before entry 1, so entry 1 is younger.
REQ-017 A transfer with addr == 0 SHALL be accepted but not enqueued, because r0 is hardwired.
REQ-018 When count > 0, ram_we SHALL be 1 and ram_addrw / ram_din SHALL equal the head entry, combinationally; the head pops at that edge.
REQ-019 When count == 0, ram_we SHALL be 0 and ram_addrw / ram_din SHALL be 0.
REQ-020 Minimum latency from accepted request to ram_we SHALL be one cycle; there is no same-cycle pass-through.
REQ-021 count_next SHALL equal count + pushes - pop.
REQ-022 Push and pop in the same cycle are legal; occupancy never exceeds DEPTH and never underflows.
REQ-023 RAM write order SHALL equal acceptance order, so the last write to any address wins.
REQ-024 fwd_hitK SHALL be 1 iff fwd_addrK != 0 and some valid queue entry has a matching address, including the head currently being written.
REQ-025 fwd_dataK SHALL be the data of the youngest matching entry; it is 0 when fwd_hitK is 0.
REQ-026 Forwarding SHALL consider only registered queue contents, not same-cycle wr0/wr1 inputs.

Reset
REQ-027 While rst is 1 at a clock edge, the block SHALL set count, head and tail to 0 and clear all entry valid bits.
REQ-028 Request data SHALL not be reset.
REQ-029 After reset: ram_we = 0, count = 0, wr0_ready = 1, wr1_ready = 1, all fwd_hitK = 0.
REQ-030 A reset asserted mid-operation SHALL discard all pending writes without issuing further RAM writes.
REQ-031 Requests presented during the reset cycle SHALL be dropped.

Configuration
REQ-032 Macro RF_WQ_FWD_EN: when defined, the forwarding logic of REQ-024 to REQ-026 SHALL be compiled in.
REQ-033 When RF_WQ_FWD_EN is undefined, fwd_hitK and fwd_dataK SHALL be tied to 0, fwd_addrK SHALL be unused, and all other behaviour SHALL be unchanged.

Verification
REQ-034 Reset, then wr0 = (addr 5, 0x11) and wr1 = (addr 7, 0x22) in one cycle -> next cycle ram_we = 1 with addr 5 / 0x11, the cycle after addr 7 / 0x22, then ram_we = 0; count goes 2, 1, 0.
REQ-035 DEPTH = 4: hold both ports valid continuously -> accepts 2, then 1 per cycle at steady state; wr1_ready = 0 whenever count >= 3, wr0_ready = 0 only at count = 4; no overflow.
REQ-036 wr0 with addr 0, data 0xFF, plus wr1 with addr 3 -> only addr 3 is written; count = 1.
REQ-037 (RF_WQ_FWD_EN) enqueue addr 9 = 0xA then addr 9 = 0xB; fwd_addr1 = 9 -> fwd_hit1 = 1, fwd_data1 = 0xB until the second write drains, then hit = 0; fwd_addr0 = 0 -> hit = 0.
REQ-038 Fill 3 entries, assert rst for one cycle -> ram_we = 0 and count = 0 the next cycle; none of the pending entries is ever written.
REQ-039 Without RF_WQ_FWD_EN, rerun REQ-037 stimulus -> fwd_hit1 = 0 and fwd_data1 = 0 throughout; RAM write sequence identical to the enabled build.
